// File: rtl/core_pipe_fetch_cfr_pkg.sv
// Types shared by the fetch stage and its instruction buffer.
package core_pipe_fetch_cfr_pkg;
`include "core_common.svh"

    localparam int XL              = `XL;
    localparam int FETCH_BUF_DEPTH = `FETCH_BUF_DEPTH;

    typedef logic [`MEM_ADDR_R] addr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        addr_t       pc;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/core_common.svh
// Shared core constants: register width, memory address range and fetch buffer depth.
`ifndef CORE_COMMON_SVH
`define CORE_COMMON_SVH
`define XL 63
`define MEM_ADDR_R `XL:0
`define FETCH_BUF_DEPTH 2
`endif

// File: rtl/core_pipe_fetch_cfr_buf.sv
// core_fetch_buffer: small FIFO of fetched instructions; flush drops all entries and wins over push/pop.
module core_fetch_buffer
    import core_pipe_fetch_cfr_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                       g_clk,
    input  logic                       g_reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               pop_data,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge g_clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/core_pipe_fetch_cfr.sv
// Instruction fetch stage with control-flow redirect and in-flight response discard.
// Optional CORE_FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module core_pipe_fetch_cfr
    import core_pipe_fetch_cfr_pkg::*;
#(
    parameter logic [63:0] RESET_ADDR      = 64'h0000_0000_0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        cf_valid,
    output logic        cf_ack,
    input  logic [XL:0] cf_target,
    output logic        imem_req,
    input  logic        imem_gnt,
    output logic [XL:0] imem_addr,
    input  logic        imem_recv,
    output logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_data,
    output logic [XL:0] f_pc,
    output logic        f_err
);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BCW = $clog2(FETCH_BUF_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    addr_t         fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    addr_t         pcq_q [MAX_OUTSTANDING];
    addr_t         pcq_d [MAX_OUTSTANDING];
    logic [CW-1:0] pcq_cnt_q, pcq_cnt_d;

    logic          gnt_fire, resp_fire, resp_drop, resp_run, cf_fire, bypass;
    logic          req_ok, buf_full, buf_empty, buf_push, buf_pop;
    logic [BCW-1:0] buf_count;
    fetch_entry_t  resp_entry, buf_head, out_entry;

    // Requests only ever add to outstanding+buffered, so a raised request stays legal until granted.
    assign req_ok    = ((int'(outst_q) + int'(buf_count)) < FETCH_BUF_DEPTH)
                    && (int'(outst_q) < MAX_OUTSTANDING);
    assign imem_req  = !g_reset && req_ok;
    assign imem_addr = fetch_pc_q;
    assign cf_ack    = !g_reset && cf_valid && (!imem_req || imem_gnt);
    assign imem_ack  = !g_reset && ((state_q == ST_DRAIN) || !buf_full);

    assign gnt_fire  = imem_req && imem_gnt;
    assign resp_fire = imem_recv && imem_ack;
    assign resp_drop = resp_fire && (state_q == ST_DRAIN);
    assign resp_run  = resp_fire && (state_q == ST_RUN);
    assign cf_fire   = cf_valid && cf_ack;

`ifdef CORE_FETCH_BYPASS_EN
    assign bypass = resp_run && buf_empty;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        resp_entry.data = imem_rdata;
        resp_entry.err  = imem_error;
        resp_entry.pc   = pcq_q[0];
        out_entry       = buf_empty ? resp_entry : buf_head;
    end

    assign f_valid  = !buf_empty || bypass;
    assign f_data   = out_entry.data;
    assign f_err    = out_entry.err;
    assign f_pc     = out_entry.pc;
    assign buf_push = resp_run && !(bypass && f_ready);
    assign buf_pop  = f_ready && !buf_empty;

    core_fetch_buffer #(.DEPTH(FETCH_BUF_DEPTH)) u_buf (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .push      (buf_push),
        .push_data (resp_entry),
        .pop       (buf_pop),
        .pop_data  (buf_head),
        .flush     (cf_fire),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (cf_fire) begin
            fetch_pc_d = cf_target;
        end else if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 4;
        end
        outst_d   = outst_q + CW'(gnt_fire) - CW'(resp_fire);
        discard_d = discard_q - CW'(resp_drop);
        // Everything still in flight after this edge is stale, including requests already
        // marked for discard, so outst_d (never above MAX_OUTSTANDING) is the new discard count.
        if (cf_fire) begin
            discard_d = outst_d;
        end
    end

    // PC queue only tracks requests whose responses will be kept.
    always_comb begin
        pcq_d     = pcq_q;
        pcq_cnt_d = pcq_cnt_q;
        if (cf_fire) begin
            pcq_cnt_d = '0;
        end else begin
            if (resp_run) begin
                for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
                    pcq_d[i] = pcq_q[i + 1];
                end
                pcq_cnt_d = pcq_cnt_d - 1'b1;
            end
            if (gnt_fire) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (pcq_cnt_d == CW'(i)) begin
                        pcq_d[i] = fetch_pc_q;
                    end
                end
                pcq_cnt_d = pcq_cnt_d + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = (discard_d != '0) ? ST_DRAIN : ST_RUN;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_ADDR[XL:0];
            outst_q    <= '0;
            discard_q  <= '0;
            pcq_cnt_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                pcq_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            pcq_cnt_q  <= pcq_cnt_d;
            pcq_q      <= pcq_d;
        end
    end
endmodule

// File: tb/tb_core_pipe_fetch_cfr.sv
// Bench for core_pipe_fetch_cfr: random memory/decode/redirect traffic against an architectural fetch model.
module tb_core_pipe_fetch_cfr;
    localparam logic [63:0] RA = 64'h0000_0000_8000_0000;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        cf_valid, cf_ack;
    logic [63:0] cf_target;
    logic        imem_req, imem_gnt;
    logic [63:0] imem_addr;
    logic        imem_recv, imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_error;
    logic        f_valid, f_ready;
    logic [31:0] f_data;
    logic [63:0] f_pc;
    logic        f_err;

    core_pipe_fetch_cfr #(.RESET_ADDR(RA), .MAX_OUTSTANDING(2)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .cf_valid(cf_valid), .cf_ack(cf_ack), .cf_target(cf_target),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_error(imem_error),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data), .f_pc(f_pc), .f_err(f_err)
    );

    always #5 g_clk = ~g_clk;

    int checks = 0;
    int failures = 0;

    // Stimulus knobs (percent) and directed redirect override.
    int p_gnt, p_recv, p_rdy, p_cf;
    bit force_cf;
    logic [63:0] force_tgt;

    // Architectural model: memory queue of granted addresses, next delivered PC, next fetch PC.
    logic [63:0] memq[$];
    logic [63:0] exp_fpc, exp_ipc;
    bit prev_stall, last_cf_fire;
    logic [63:0] fpc_log[$];
    logic        ferr_log[$];
    logic [63:0] gnt_log[$];
    int n_gnt, n_deliv, cyc, first_resp, first_fv;

    function automatic logic [31:0] memdata(logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_F00F;
    endfunction

    function automatic logic errfn(logic [63:0] a);
        return a[5:2] == 4'd2;
    endfunction

    function automatic logic [63:0] qget(logic [63:0] q[$], int i);
        return (i < q.size()) ? q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        fpc_log.delete();
        ferr_log.delete();
        gnt_log.delete();
        exp_fpc = RA;
        exp_ipc = RA;
        prev_stall = 0;
        last_cf_fire = 0;
        first_resp = -1;
        first_fv = -1;
    endtask

    task automatic drive();
        imem_gnt = ($urandom_range(99) < p_gnt);
        f_ready  = ($urandom_range(99) < p_rdy);
        if (force_cf) begin
            cf_valid  = 1'b1;
            cf_target = force_tgt;
        end else if (!(cf_valid && !last_cf_fire)) begin
            cf_valid  = ($urandom_range(99) < p_cf);
            cf_target = {RA[63:12], 10'($urandom), 2'b00};
        end
        if (memq.size() > 0 && $urandom_range(99) < p_recv) begin
            imem_recv  = 1'b1;
            imem_rdata = memdata(memq[0]);
            imem_error = errfn(memq[0]);
        end else begin
            imem_recv  = 1'b0;
            imem_rdata = $urandom;
            imem_error = 1'($urandom);
        end
    endtask

    // The per-cycle compare against the model; inputs are stable, outputs settled.
    task automatic model_check();
        bit g, r, c;
        if (g_reset) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_f_valid", f_valid, 0);
            chk("rst_cf_ack", cf_ack, 0);
            return;
        end
        cyc++;
        chk("cf_ack_rule", cf_ack, cf_valid && (!imem_req || imem_gnt));
        if (prev_stall) chk("req_held", imem_req, 1);
        if (imem_req) chk("imem_addr", imem_addr, exp_ipc);
        chk("outstanding_limit", imem_req && (memq.size() >= 2), 0);
        if (f_valid && first_fv < 0) first_fv = cyc;
        if (f_valid && f_ready) begin
            chk("f_pc", f_pc, exp_fpc);
            chk("f_data", f_data, memdata(exp_fpc));
            chk("f_err", f_err, errfn(exp_fpc));
            fpc_log.push_back(f_pc);
            ferr_log.push_back(f_err);
            n_deliv++;
            exp_fpc += 4;
        end
        g = imem_req && imem_gnt;
        r = imem_recv && imem_ack;
        c = cf_valid && cf_ack;
        if (r) begin
            void'(memq.pop_front());
            if (first_resp < 0) first_resp = cyc;
        end
        if (g) begin
            memq.push_back(imem_addr);
            gnt_log.push_back(imem_addr);
            n_gnt++;
        end
        if (c) begin
            exp_fpc = cf_target;
            exp_ipc = cf_target;
        end else if (g) begin
            exp_ipc += 4;
        end
        prev_stall = imem_req && !imem_gnt;
        last_cf_fire = c;
    endtask

    task automatic fin();
        @(negedge g_clk);
        model_check();
        @(posedge g_clk);
        #1;
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            drive();
            fin();
        end
    endtask

    task automatic knobs(int g, int r, int y, int c);
        p_gnt = g; p_recv = r; p_rdy = y; p_cf = c;
    endtask

    initial begin
        int base, idx;
        logic [63:0] held;
        g_reset = 1'b1;
        imem_gnt = 0; imem_recv = 0; imem_rdata = 0; imem_error = 0; f_ready = 1;
        force_cf = 1; force_tgt = 64'h8000_0040;
        cf_valid = 1; cf_target = force_tgt;
        n_gnt = 0; n_deliv = 0; cyc = 0;
        model_reset();
        knobs(100, 100, 100, 0);
        repeat (3) begin
            @(negedge g_clk);
            model_check();
        end
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        force_cf = 0; cf_valid = 0;

        // Reset release, grant always, one-cycle responses.
        drive(); #1;
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, RA);
        fin();
        step(19);
        chk("gnt0", qget(gnt_log, 0), RA);
        chk("gnt1", qget(gnt_log, 1), RA + 4);
        chk("gnt2", qget(gnt_log, 2), RA + 8);
        chk("fpc0", qget(fpc_log, 0), RA);
        chk("fpc1", qget(fpc_log, 1), RA + 4);
        chk("err_at_08", (ferr_log.size() > 2) ? ferr_log[2] : 1'bx, 1);
        chk("err_at_0c", (ferr_log.size() > 3) ? ferr_log[3] : 1'bx, 0);
        chk("fpc3_after_err", qget(fpc_log, 3), RA + 12);
`ifdef CORE_FETCH_BYPASS_EN
        chk("resp_to_fvalid_latency", 64'(first_fv - first_resp), 0);
`else
        chk("resp_to_fvalid_latency", 64'(first_fv - first_resp), 1);
`endif

        // Two outstanding, then redirect: stale responses dropped.
        knobs(100, 0, 100, 0);
        step(6);
        drive(); #1;
        chk("two_outst_req_low", imem_req, 0);
        fin();
        force_cf = 1; force_tgt = 64'h8000_0100;
        drive(); #1;
        chk("redirect_ack", cf_ack, 1);
        fin();
        force_cf = 0;
        fpc_log.delete();
        knobs(100, 100, 100, 0);
        step(15);
        chk("first_after_redirect", qget(fpc_log, 0), 64'h8000_0100);
        chk("second_after_redirect", qget(fpc_log, 1), 64'h8000_0104);

        // Request stalled without grant: redirect must wait for it.
        knobs(0, 100, 100, 0);
        step(6);
        drive(); #1;
        chk("stall_req_high", imem_req, 1);
        held = imem_addr;
        fin();
        force_cf = 1; force_tgt = 64'h8000_0200;
        for (int i = 0; i < 3; i++) begin
            drive(); #1;
            chk("stall_cf_ack_low", cf_ack, 0);
            chk("stall_addr_held", imem_addr, held);
            fin();
        end
        p_gnt = 100;
        drive(); #1;
        chk("grant_cf_ack", cf_ack, 1);
        fin();
        force_cf = 0;
        fpc_log.delete();
        step(12);
        chk("first_after_stall_redirect", qget(fpc_log, 0), 64'h8000_0200);

        // Decode backpressure: buffer fills, then one pop allows exactly one request.
        knobs(100, 100, 0, 0);
        step(12);
        drive(); #1;
        chk("full_req_low", imem_req, 0);
        chk("full_ack_low", imem_ack, 0);
        chk("full_f_valid", f_valid, 1);
        fin();
        base = n_gnt;
        p_rdy = 100;
        step(1);
        p_rdy = 0;
        step(8);
        chk("one_pop_one_req", 64'(n_gnt - base), 1);

        // Randomized traffic.
        knobs(70, 60, 70, 5);
        base = n_deliv;
        step(3000);
        chk("random_progress", 64'(n_deliv - base > 100), 1);

        // Reset pulsed while draining.
        knobs(100, 0, 100, 0);
        step(8);
        force_cf = 1; force_tgt = 64'h8000_0300;
        drive(); #1;
        chk("drain_entry_ack", cf_ack, 1);
        fin();
        drive();
        #2;
        g_reset = 1'b1;
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_fvalid", f_valid, 0);
        chk("async_rst_cfack", cf_ack, 0);
        model_reset();
        force_cf = 0; cf_valid = 0;
        fin();
        step(2);
        g_reset = 1'b0;
        knobs(100, 100, 100, 0);
        drive(); #1;
        chk("post_drain_rst_req", imem_req, 1);
        chk("post_drain_rst_addr", imem_addr, RA);
        fin();
        step(10);
        idx = 0;
        chk("post_drain_rst_fpc0", qget(fpc_log, idx), RA);
        chk("post_drain_rst_fpc1", qget(fpc_log, idx + 1), RA + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
